// File: rtl/demux_frame_router.sv
// demux_frame_router: serial frame receiver driving the select/data inputs of a 1-to-4 demux.
// Optional trailing even-parity bit enabled by defining DEMUX_PARITY_EN.
`default_nettype none

module demux_frame_router #(
  parameter int PAYLOAD_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_bit,
  input  logic rx_valid,
  output logic s0,
  output logic s1,
  output logic route_data,
  output logic frame_active,
  output logic frame_done,
  output logic parity_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_PAYLOAD,
`ifdef DEMUX_PARITY_EN
    ST_PARITY,
`endif
    ST_DONE
  } state_t;

  localparam logic [7:0] c_last_cnt = 8'(PAYLOAD_LEN);

  state_t     state_q;
  logic       addr_hi_q;
  logic       s0_q;
  logic       s1_q;
  logic       route_q;
  logic       active_q;
  logic       done_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
`ifdef DEMUX_PARITY_EN
  logic       par_q;
  logic       perr_q;
`endif

  assign cnt_d = cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_hi_q <= 1'b0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      route_q   <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= 8'd0;
`ifdef DEMUX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          route_q <= 1'b0;
          if (rx_valid && rx_bit) begin
            state_q  <= ST_ADDR_HI;
            active_q <= 1'b1;
          end
        end
        ST_ADDR_HI: begin
          if (rx_valid) begin
            addr_hi_q <= rx_bit;
`ifdef DEMUX_PARITY_EN
            par_q     <= rx_bit;
`endif
            state_q   <= ST_ADDR_LO;
          end
        end
        ST_ADDR_LO: begin
          // Both selects update on the same edge so the demux never sees a mixed address.
          if (rx_valid) begin
            s0_q    <= addr_hi_q;
            s1_q    <= rx_bit;
            cnt_q   <= 8'd0;
            route_q <= 1'b0;
`ifdef DEMUX_PARITY_EN
            par_q   <= par_q ^ rx_bit;
`endif
            state_q <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (rx_valid) begin
            route_q <= rx_bit;
            cnt_q   <= cnt_d;
`ifdef DEMUX_PARITY_EN
            par_q   <= par_q ^ rx_bit;
            if (cnt_d == c_last_cnt) begin
              state_q <= ST_PARITY;
            end
`else
            if (cnt_d == c_last_cnt) begin
              state_q  <= ST_DONE;
              active_q <= 1'b0;
              done_q   <= 1'b1;
            end
`endif
          end
        end
`ifdef DEMUX_PARITY_EN
        ST_PARITY: begin
          if (rx_valid) begin
            route_q  <= 1'b0;
            perr_q   <= rx_bit ^ par_q;
            active_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          route_q <= 1'b0;
          done_q  <= 1'b0;
`ifdef DEMUX_PARITY_EN
          perr_q  <= 1'b0;
`endif
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s0           = s0_q;
  assign s1           = s1_q;
  assign route_data   = route_q;
  assign frame_active = active_q;
  assign frame_done   = done_q;
`ifdef DEMUX_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

`default_nettype wire
